// File: rtl/nestn_counter.sv
// nestn_counter: runtime-programmable N-level nested counter with an
// address generator for multi-dimensional tile walks.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start, cont    begin a walk (IDLE only); continuous mode, sampled with start
//   n_max          per-level bounds, level k at [k*CW +: CW], 0 treated as 1
//   stride, base   per-level address strides, level k at [k*AW +: AW]; start address
//   ena            consumer accepts the current item (only while valid)
//   syn_rst        synchronous abort back to IDLE, highest priority
//   cnt, addr      current per-level indices; base + sum(cnt_k*stride_k) mod 2^AW
//   valid, last    live item; final item of the walk
//   done, busy     one-cycle pulse after the final accept; high in RUN
//
// Each level keeps its running offset (cnt_k*stride_k) incrementally, so the
// address needs only adders, never multipliers.

// One nest level: index counter plus running address offset.
module nestn_level #(
  parameter int CW = 16,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,      // synchronous abort
  input  logic          i_load,     // latch bound/stride, restart at 0
  input  logic          i_step,     // walk advances this cycle
  input  logic          i_carry,    // all lower levels at bound-1
  input  logic [CW-1:0] i_nmax,
  input  logic [AW-1:0] i_stride,
  output logic [CW-1:0] o_cnt,
  output logic [AW-1:0] o_off_nxt,  // offset this level will hold after the edge
  output logic          o_at_max
);
  logic [CW-1:0] r_bound, r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_stride, r_off, w_off_nxt;

  assign o_at_max  = (r_cnt == r_bound - CW'(1));
  assign o_cnt     = r_cnt;
  assign o_off_nxt = w_off_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_off_nxt = r_off;
    if (i_clr || i_load) begin
      w_cnt_nxt = '0;
      w_off_nxt = '0;
    end else if (i_step && i_carry) begin
      // Wrapping to 0 also covers the whole-walk rollover in continuous mode.
      if (o_at_max) begin
        w_cnt_nxt = '0;
        w_off_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
        w_off_nxt = r_off + r_stride;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bound  <= CW'(1);
      r_stride <= '0;
      r_cnt    <= '0;
      r_off    <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_off <= w_off_nxt;
      if (i_load && !i_clr) begin
        r_bound  <= (i_nmax == '0) ? CW'(1) : i_nmax;
        r_stride <= i_stride;
      end
    end
  end
endmodule

module nestn_counter #(
  parameter int CW   = 16,
  parameter int NEST = 3,
  parameter int AW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic [NEST*CW-1:0] n_max,
  input  logic [NEST*AW-1:0] stride,
  input  logic [AW-1:0]      base,
  input  logic               ena,
  input  logic               syn_rst,
  output logic [NEST*CW-1:0] cnt,
  output logic [AW-1:0]      addr,
  output logic               valid,
  output logic               last,
  output logic               done,
  output logic               busy
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_done, r_cont;
  logic [AW-1:0]              r_base, r_addr, w_addr_sum;
  logic                       w_load, w_step, w_done_nxt, w_last;
  logic [NEST:0]              w_carry;
  logic [NEST-1:0]            w_at_max;
  logic [NEST-1:0][AW-1:0]    w_off_nxt;
  logic [NEST-1:0][CW-1:0]    w_cnt;

  for (genvar k = 0; k < NEST; k++) begin : g_lvl
    nestn_level #(.CW(CW), .AW(AW)) u_lvl (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (syn_rst),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_carry   (w_carry[k]),
      .i_nmax    (n_max[k*CW +: CW]),
      .i_stride  (stride[k*AW +: AW]),
      .o_cnt     (w_cnt[k]),
      .o_off_nxt (w_off_nxt[k]),
      .o_at_max  (w_at_max[k])
    );
  end

  // Level k advances only when every lower level is at bound-1; the carry out
  // of the top level marks the final item of the walk.
  always_comb begin
    w_carry[0] = 1'b1;
    for (int k = 0; k < NEST; k++) w_carry[k+1] = w_carry[k] & w_at_max[k];
  end
  assign w_last = w_carry[NEST];

  // Priority: syn_rst > start > ena. start is only seen in IDLE, ena only in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_done_nxt  = 1'b0;
    if (syn_rst) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_load      = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (ena) begin
            w_step = 1'b1;
            if (w_last) begin
              w_done_nxt = 1'b1;
              if (!r_cont) w_state_nxt = S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Next address from the levels' next offsets; on load the fresh base is used.
  always_comb begin
    w_addr_sum = w_load ? base : r_base;
    for (int k = 0; k < NEST; k++) w_addr_sum = w_addr_sum + w_off_nxt[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_cont  <= 1'b0;
      r_base  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_base <= base;
        r_cont <= cont;
      end
      if (syn_rst)               r_addr <= '0;
      else if (w_load || w_step) r_addr <= w_addr_sum;
    end
  end

  assign cnt   = w_cnt;
  assign addr  = r_addr;
  assign valid = (r_state == S_RUN);
  assign busy  = (r_state == S_RUN);
  assign last  = (r_state == S_RUN) && w_last;
  assign done  = r_done;
endmodule

// File: tb/tb_nestn_counter.sv
module tb_nestn_counter;
  localparam int CW = 16, NEST = 3, AW = 32;

  logic               clk = 1'b0;
  logic               rst, start, cont, ena, syn_rst;
  logic [NEST*CW-1:0] n_max, cnt;
  logic [NEST*AW-1:0] stride;
  logic [AW-1:0]      base, addr;
  logic               valid, last, done, busy;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  nestn_counter #(.CW(CW), .NEST(NEST), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .n_max(n_max),
    .stride(stride), .base(base), .ena(ena), .syn_rst(syn_rst),
    .cnt(cnt), .addr(addr), .valid(valid), .last(last), .done(done), .busy(busy)
  );

  // Reference model: the walk is an item index into the mixed-radix space.
  bit             m_run, m_done, m_cont, m_zero;
  int unsigned    m_idx, m_total;
  int unsigned    m_b[NEST];
  logic [AW-1:0]  m_s[NEST];
  logic [AW-1:0]  m_base;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_cont = 0; m_zero = 1; m_idx = 0; m_total = 1;
    m_base = '0;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (syn_rst) begin
      m_run = 0; m_idx = 0; m_zero = 1;
    end else if (!m_run && start) begin
      m_total = 1;
      for (int k = 0; k < NEST; k++) begin
        m_b[k] = (n_max[k*CW +: CW] == 0) ? 1 : int'(n_max[k*CW +: CW]);
        m_s[k] = stride[k*AW +: AW];
        m_total *= m_b[k];
      end
      m_base = base; m_cont = cont; m_run = 1; m_idx = 0; m_zero = 0;
    end else if (m_run && ena) begin
      if (m_idx == m_total - 1) begin
        m_done = 1; m_idx = 0;
        if (!m_cont) m_run = 0;
      end else m_idx++;
    end
  endtask

  task automatic model_check();
    logic [NEST*CW-1:0] ec;
    logic [AW-1:0]      ea;
    int unsigned        dv, c;
    ec = '0; ea = m_base; dv = 1;
    if (m_run)
      for (int k = 0; k < NEST; k++) begin
        c = (m_idx / dv) % m_b[k];
        ec[k*CW +: CW] = CW'(c);
        ea = ea + m_s[k] * AW'(c);
        dv *= m_b[k];
      end
    chk("valid", 64'(valid), 64'(m_run));
    chk("busy",  64'(busy),  64'(m_run));
    chk("last",  64'(last),  64'(m_run && m_idx == m_total - 1));
    chk("done",  64'(done),  64'(m_done));
    chk("cnt",   64'(cnt),   64'(ec));
    if (m_run)       chk("addr", 64'(addr), 64'(ea));
    else if (m_zero) chk("addr_zero", 64'(addr), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  typedef struct {
    bit            st, en;
    logic [AW-1:0] bs;
    logic [CW-1:0] n0;
    logic [AW-1:0] s0;
    bit            e_valid, e_last, e_done, ck_addr;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t tbl[9];
  int   items;

  initial begin
    rst = 1; start = 0; cont = 0; ena = 0; syn_rst = 0;
    n_max = '0; stride = '0; base = '0;
    model_reset();
    #12;
    model_check();
    rst = 0;
    @(negedge clk);

    // Boundary table: all-ones bounds, address wrap, idle/run input masking.
    tbl[0] = '{1, 0, 32'hFFFFFFFF, 16'd1, 32'd0, 1, 1, 0, 1, 32'hFFFFFFFF};
    tbl[1] = '{0, 1, 32'hFFFFFFFF, 16'd1, 32'd0, 0, 0, 1, 0, 32'd0};
    tbl[2] = '{1, 0, 32'hFFFFFFFF, 16'd2, 32'd2, 1, 0, 0, 1, 32'hFFFFFFFF};
    tbl[3] = '{0, 1, 32'hFFFFFFFF, 16'd2, 32'd2, 1, 1, 0, 1, 32'h00000001};
    tbl[4] = '{0, 1, 32'hFFFFFFFF, 16'd2, 32'd2, 0, 0, 1, 0, 32'd0};
    tbl[5] = '{0, 1, 32'hFFFFFFFF, 16'd2, 32'd2, 0, 0, 0, 0, 32'd0};
    tbl[6] = '{1, 1, 32'd5,        16'd0, 32'd3, 1, 1, 0, 1, 32'd5};
    tbl[7] = '{1, 0, 32'd9,        16'd2, 32'd3, 1, 1, 0, 1, 32'd5};
    tbl[8] = '{0, 1, 32'd9,        16'd2, 32'd3, 0, 0, 1, 0, 32'd0};
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].st; ena = tbl[i].en; base = tbl[i].bs; cont = 0;
      n_max = {32'd0, tbl[i].n0}; stride = {64'd0, tbl[i].s0};
      tick();
      chk("tbl_valid", 64'(valid), 64'(tbl[i].e_valid));
      chk("tbl_last",  64'(last),  64'(tbl[i].e_last));
      chk("tbl_done",  64'(done),  64'(tbl[i].e_done));
      if (tbl[i].ck_addr) chk("tbl_addr", 64'(addr), 64'(tbl[i].e_addr));
    end
    start = 0; ena = 0; tick();

    // 2x3x4 walk with ena held high: addresses 100..123.
    n_max = {16'd4, 16'd3, 16'd2}; stride = {32'd6, 32'd2, 32'd1}; base = 100;
    start = 1; tick(); start = 0; ena = 1;
    for (int i = 0; i < 24; i++) begin
      chk("seq_addr", 64'(addr), 64'(100 + i));
      chk("seq_last", 64'(last), 64'(i == 23));
      tick();
    end
    chk("seq_done", 64'(done), 64'd1);
    chk("seq_valid_drop", 64'(valid), 64'd0);
    ena = 0; tick();
    chk("seq_done_once", 64'(done), 64'd0);

    // Same walk with ena toggling.
    start = 1; tick(); start = 0; items = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      ena = c[0];
      if (ena && valid) begin
        chk("tog_addr", 64'(addr), 64'(100 + items));
        items++;
      end
      tick();
    end
    chk("tog_items", 64'(items), 64'd24);
    chk("tog_done", 64'(done), 64'd1);
    ena = 0; tick();

    // Middle bound 0 behaves as 1: 8 consecutive addresses.
    n_max = {16'd4, 16'd0, 16'd2}; stride = {32'd2, 32'd0, 32'd1}; base = 500;
    start = 1; tick(); start = 0; ena = 1;
    for (int i = 0; i < 8; i++) begin
      chk("z_addr", 64'(addr), 64'(500 + i));
      tick();
    end
    chk("z_done", 64'(done), 64'd1);

    // Continuous mode: two identical passes.
    n_max = {16'd4, 16'd3, 16'd2}; stride = {32'd6, 32'd2, 32'd1}; base = 100;
    ena = 0; cont = 1; start = 1; tick(); start = 0; cont = 0; ena = 1;
    for (int i = 0; i < 48; i++) begin
      chk("cont_addr", 64'(addr), 64'(100 + (i % 24)));
      chk("cont_valid", 64'(valid), 64'd1);
      tick();
      chk("cont_done", 64'(done), 64'((i % 24) == 23));
    end

    // syn_rst on item 10, then restart.
    syn_rst = 1; ena = 0; tick(); syn_rst = 0;
    start = 1; tick(); start = 0; ena = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("sr_item10", 64'(addr), 64'd110);
    syn_rst = 1; tick(); syn_rst = 0;
    chk("sr_valid", 64'(valid), 64'd0);
    chk("sr_addr", 64'(addr), 64'd0);
    chk("sr_cnt", 64'(cnt), 64'd0);
    chk("sr_done", 64'(done), 64'd0);
    ena = 0; start = 1; tick(); start = 0;
    chk("sr_restart", 64'(addr), 64'd100);

    // Async rst at item 5 clears before the next edge.
    ena = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("ar_item5", 64'(addr), 64'd105);
    #2 rst = 1;
    #1 model_reset();
    chk("ar_valid", 64'(valid), 64'd0);
    chk("ar_addr", 64'(addr), 64'd0);
    chk("ar_cnt", 64'(cnt), 64'd0);
    #1 rst = 0;
    ena = 0; start = 1; tick(); start = 0;
    chk("ar_restart", 64'(addr), 64'd100);
    syn_rst = 1; tick(); syn_rst = 0;

    // Randomized walks against the model.
    for (int w = 0; w < 30; w++) begin
      for (int k = 0; k < NEST; k++) begin
        n_max[k*CW +: CW] = CW'($urandom_range(0, 4));
        stride[k*AW +: AW] = $urandom;
      end
      base = $urandom; cont = $urandom_range(0, 1); ena = 0;
      start = 1; tick(); start = 0;
      for (int c = 0; c < 150; c++) begin
        ena     = ($urandom_range(0, 3) != 0);
        syn_rst = ($urandom_range(0, 99) == 0);
        start   = ($urandom_range(0, 9) == 0);
        tick();
      end
      start = 0; ena = 0; syn_rst = 1; tick(); syn_rst = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nestn_counter.md
# nestn_counter

Runtime-programmable N-level nested counter with an address generator, for multi-dimensional tile walks in the accelerator's load/store and compute loops. It generalises the fixed two-level counter: the nest depth is a parameter, and the per-level bounds, strides and base address are loaded at run time. It adds a valid/last/done handshake and an optional continuous (auto-wrap) mode. It sits between a tile controller, which issues `start`, and a memory-port or buffer-read stage, which consumes `addr` and `cnt` and asserts `ena`.

## Interface
- CW, 16, width of each level counter and each bound
- NEST, 3, number of nest levels, legal range 1..4; level 0 is innermost
- AW, 32, width of addresses and strides

- clk  in  1  clock; all state is updated on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  loads `n_max`, `stride` and `base`, then begins a walk; honoured in IDLE only
- cont  in  1  continuous mode; sampled together with `start`
- n_max  in  NEST*CW  level k bound at bits [k*CW +: CW]; a value of 0 is treated as 1
- stride  in  NEST*AW  level k address stride at bits [k*AW +: AW]
- base  in  AW  start address
- ena  in  1  consumer accepts the current item; ignored unless `valid` is high
- syn_rst  in  1  synchronous abort back to IDLE
- cnt  out  NEST*CW  current per-level indices, packed like `n_max`
- addr  out  AW  base + Σ cnt_k*stride_k, modulo 2^AW
- valid  out  1  `cnt` and `addr` hold a live item
- last  out  1  the current item is the final item of the walk (every level at bound-1)
- done  out  1  one-cycle pulse after the final item is accepted
- busy  out  1  high in RUN

## Operation
- States: IDLE and RUN. Reset enters IDLE with `cnt`=0, `addr`=0, `valid`=0, `last`=0, `done`=0 and `busy`=0.
- IDLE, on `start`:
  - Latch the bounds, with 0 replaced by 1, plus the strides, `base` and `cont`.
  - Go to RUN with `cnt`=0, `addr`=`base`, `valid`=1.
  - `last` is high immediately when every bound is 1.
- RUN, on `ena`:
  - Level 0 increments.
  - Level k (k>0) increments only when every lower level is at its bound-1. Those lower levels wrap to 0 in the same cycle.
  - `addr` tracks `cnt` exactly in the same cycle. It is registered, never a combinational function of `ena`.
- RUN, on `ena` with `last`=1:
  - With `cont`=0: go to IDLE, `valid`=0, `cnt`=0, `done`=1 for one cycle.
  - With `cont`=1: stay in RUN, `cnt`=0, `addr`=`base`, `valid` stays 1, `done`=1 for one cycle.
- RUN without `ena`: all outputs hold their values.
- Priority is `syn_rst` > `start` > `ena`.
  - `syn_rst` in any state: go to IDLE, `cnt`=0, `addr`=0, `valid`=0, no `done` pulse.
  - `start` while in RUN is ignored.
  - When `start` and `ena` are both high in IDLE, `ena` is ignored.
- Address arithmetic is unsigned modulo 2^AW. Products and sums silently wrap.
- Total items per walk = Π bound_k. Each index tuple is emitted exactly once, in lexicographic order with level NEST-1 most significant.

## Timing
- From `start` at edge t: `valid`, `cnt`=0 and `addr`=`base` are visible after edge t.
- Throughput is one item per cycle while `ena` is held high.
- `ena` sampled at edge t produces the next item after edge t.
- The final `ena` at edge t produces `done`=1 during the cycle after t.
  - With `cont`=0, `valid` and `busy` drop after the same edge.
- A new `start` is accepted in the cycle `done` is high, since the block is already in IDLE. The walk with `cont`=0 is therefore back-to-back capable with a one-cycle gap.
- `rst` clears state immediately, without waiting for a clock edge.

## Test plan
- NEST=3, n_max=(2,3,4), stride=(1,2,6), base=100, `ena` held high: `addr` runs 100..123 consecutively; `last` is high on the 24th item only; `done` pulses once, one cycle later; then `valid`=0.
- Same setup with `ena` toggling every other cycle: identical 24-item sequence with no skips or repeats; `cnt` and `addr` hold steady while `ena` is low.
- n_max=(2,0,4), stride=(1,0,2): level 1 stays at 0; 8 items with `addr`=base+{0,1,2,...,7}; `done` after the 8th item.
- `cont`=1, same setup as the first test: after item 24, `addr` returns to 100 with `valid` still high and `done` pulsing once; a second pass produces the identical sequence.
- `syn_rst` asserted on item 10: next cycle `valid`=0, `cnt`=0, `addr`=0, no `done`. Async `rst` at item 5 clears outputs before the next clock edge. A following `start` restarts from `base`.
- All bounds 1 with base=0xFFFFFFFF: `last`=1 on the first item; one `ena` gives `done`. With stride0=2 and n_max0=2, the second item's `addr` wraps to 0x00000001.
